// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared state encodings and strobe polarity for the frame ring buffer.
package frame_buf_pkg;
    typedef enum logic {WR_FILL, WR_BLOCKED} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;
    localparam logic ASSERT   = 1'b0;
    localparam logic DEASSERT = 1'b1;
endpackage

// File: rtl/data_mem.sv
// data_mem: simple dual-port frame storage with a 1-cycle registered read port.
module data_mem #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Read register holds its value between reads and clears on reset.
    always_ff @(posedge clk or negedge reset)
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/frame_ptr.sv
// frame_ptr: buffer-index / word-address counter; the buffer index wraps at NUM_BUFS.
module frame_ptr #(
    parameter int ADDR_WIDTH    = 3,
    parameter int BUF_SEL_WIDTH = 1,
    parameter int NUM_BUFS      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     sof,
    output logic [BUF_SEL_WIDTH-1:0] buf_idx,
    output logic [ADDR_WIDTH-1:0]    word_addr,
    output logic                     last
);
    assign last = &word_addr;

    // A start-of-frame access lands on word 0, so the next word is 1.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            buf_idx   <= '0;
            word_addr <= '0;
        end else if (sof) begin
            word_addr <= ADDR_WIDTH'(1);
        end else if (inc) begin
            word_addr <= word_addr + 1'b1;
            if (last)
                buf_idx <= (buf_idx == BUF_SEL_WIDTH'(NUM_BUFS - 1)) ? '0 : buf_idx + 1'b1;
        end
endmodule

// File: rtl/frame_buf_ring.sv
// frame_buf_ring: NUM_BUFS-deep ring of whole frames, filled sequentially and drained in FIFO order.
module frame_buf_ring
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 3,
    parameter int FRAME_DEPTH   = 1 << ADDR_WIDTH,
    parameter int NUM_BUFS      = 2,
    parameter int BUF_SEL_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_in,
    input  logic                     wr_sof,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     wr_rdy,
    input  logic                     rd_en_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     rd_valid,
    output logic                     rd_sof,
    output logic                     rd_eof,
    output logic [BUF_SEL_WIDTH:0]   frames_avail,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam logic [BUF_SEL_WIDTH:0] FULL = (BUF_SEL_WIDTH+1)'(NUM_BUFS);

    wr_state_t                wr_state;
    rd_state_t                rd_state;
    logic [BUF_SEL_WIDTH-1:0] wr_buf, rd_buf;
    logic [ADDR_WIDTH-1:0]    wr_addr, rd_addr;
    logic                     wr_last, rd_last;
    logic                     wr_acc, wr_sof_acc, wr_done, rd_acc, rd_done;
    logic [BUF_SEL_WIDTH:0]   avail_next;

    assign wr_acc     = (wr_en_in == ASSERT) && wr_rdy;
    assign wr_sof_acc = wr_acc && (wr_sof == ASSERT);
    assign wr_done    = wr_acc && !wr_sof_acc && wr_last;
    assign rd_acc     = (rd_en_in != DEASSERT) && (frames_avail != '0);
    assign rd_done    = rd_acc && rd_last;
    assign avail_next = frames_avail + (BUF_SEL_WIDTH+1)'(wr_done) - (BUF_SEL_WIDTH+1)'(rd_done);

    frame_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .BUF_SEL_WIDTH(BUF_SEL_WIDTH), .NUM_BUFS(NUM_BUFS)) u_wr_ptr (
        .clk(clk), .reset(reset), .inc(wr_acc), .sof(wr_sof_acc),
        .buf_idx(wr_buf), .word_addr(wr_addr), .last(wr_last)
    );

    frame_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .BUF_SEL_WIDTH(BUF_SEL_WIDTH), .NUM_BUFS(NUM_BUFS)) u_rd_ptr (
        .clk(clk), .reset(reset), .inc(rd_acc), .sof(1'b0),
        .buf_idx(rd_buf), .word_addr(rd_addr), .last(rd_last)
    );

    data_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH + BUF_SEL_WIDTH)) u_mem (
        .clk(clk), .reset(reset),
        .we(wr_acc), .waddr({wr_buf, wr_sof_acc ? '0 : wr_addr}), .wdata(data_in),
        .re(rd_acc), .raddr({rd_buf, rd_addr}), .rdata(data_out)
    );

    // Completing the last free buffer blocks the writer until the reader frees one.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_state <= WR_FILL;
            wr_rdy   <= 1'b1;
        end else if (wr_state == WR_FILL && wr_done && avail_next == FULL) begin
            wr_state <= WR_BLOCKED;
            wr_rdy   <= 1'b0;
        end else if (wr_state == WR_BLOCKED && rd_done) begin
            wr_state <= WR_FILL;
            wr_rdy   <= 1'b1;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rd_state     <= RD_IDLE;
            frames_avail <= '0;
            rd_valid     <= 1'b0;
            rd_sof       <= 1'b0;
            rd_eof       <= 1'b0;
        end else begin
            frames_avail <= avail_next;
            rd_valid     <= rd_acc;
            rd_sof       <= rd_acc && (rd_addr == '0);
            rd_eof       <= rd_done;
            if (rd_state == RD_IDLE && rd_acc)
                rd_state <= RD_DRAIN;
            else if (rd_state == RD_DRAIN && rd_done)
                rd_state <= (avail_next != '0) ? RD_DRAIN : RD_IDLE;
        end

    // Overflow is sticky; a new event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset)
        if (!reset) overflow <= 1'b0;
        else if (wr_en_in == ASSERT && !wr_rdy) overflow <= 1'b1;
        else if (ovf_clr == ASSERT) overflow <= 1'b0;
endmodule

// File: tb/tb_frame_buf_ring.sv
// tb_frame_buf_ring: randomized and directed stimulus checked by a frame-queue reference model and scoreboard.
module tb_frame_buf_ring;
    localparam int DW = 24, AW = 3, FD = 1 << AW, NB = 2, BS = 1;

    logic          clk = 0, reset = 1;
    logic          wr_en_in = 1, wr_sof = 1, rd_en_in = 1, ovf_clr = 1;
    logic [DW-1:0] data_in = '0, data_out;
    logic          wr_rdy, rd_valid, rd_sof, rd_eof, overflow;
    logic [BS:0]   frames_avail;

    frame_buf_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFS(NB), .BUF_SEL_WIDTH(BS)) dut (
        .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_sof(wr_sof), .data_in(data_in),
        .wr_rdy(wr_rdy), .rd_en_in(rd_en_in), .data_out(data_out), .rd_valid(rd_valid),
        .rd_sof(rd_sof), .rd_eof(rd_eof), .frames_avail(frames_avail), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic s; logic e; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] done_q[$], part_q[$];
    int            rd_idx = 0;
    logic          m_ovf = 0;
    bit            chk_en = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_count();
        return (done_q.size() + rd_idx) / FD;
    endfunction

    // Scoreboard monitor: compare every cycle, just after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (chk_en) begin
            check("rd_valid", rd_valid, exp_q.size() != 0);
            if (rd_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data_out", data_out, e.d);
                check("rd_sof", rd_sof, e.s);
                check("rd_eof", rd_eof, e.e);
            end
            check("frames_avail", frames_avail, m_count());
            check("wr_rdy", wr_rdy, m_count() < NB);
            check("overflow", overflow, m_ovf);
        end
    end

    // Drive one cycle and advance the model to the state after the coming edge.
    task automatic cyc(input bit we, input bit sof, input logic [DW-1:0] d, input bit re, input bit clr);
        int   cnt;
        exp_t e;
        @(negedge clk);
        wr_en_in = !we; wr_sof = !sof; data_in = d; rd_en_in = !re; ovf_clr = !clr;
        cnt = m_count();
        if (we && cnt >= NB) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (re && cnt > 0) begin
            e.d = done_q.pop_front(); e.s = (rd_idx == 0); e.e = (rd_idx == FD - 1);
            exp_q.push_back(e);
            rd_idx = (rd_idx + 1) % FD;
        end
        if (we && cnt < NB) begin
            if (sof) part_q = {d};
            else part_q.push_back(d);
            if (part_q.size() == FD) begin
                foreach (part_q[i]) done_q.push_back(part_q[i]);
                part_q = {};
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_rdy", wr_rdy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_sof", rd_sof, 0);
        check("rst_rd_eof", rd_eof, 0);
        check("rst_frames_avail", frames_avail, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data_out", data_out, 0);
    endtask

    initial begin
        #2 reset = 0;
        #1 check_reset_outputs();
        @(negedge clk); @(negedge clk);
        reset = 1; chk_en = 1;

        // Single frame in, single frame out.
        for (int i = 1; i <= FD; i++) cyc(1, 0, DW'(i), 0, 0);
        for (int i = 0; i < FD; i++) cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);

        // Fill both buffers, overflow, clear, release one frame.
        for (int i = 0; i < 2*FD; i++) cyc(1, 0, DW'($urandom), 0, 0);
        cyc(1, 0, 24'hDEAD01, 0, 0);
        cyc(0, 0, '0, 0, 1);
        for (int i = 0; i < FD; i++) cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);

        // One frame held; finish the next frame on the same edge the held one is released.
        for (int i = 0; i < FD - 1; i++) cyc(1, 0, DW'($urandom), 1, 0);
        cyc(1, 0, 24'h5A5A5A, 1, 0);
        for (int i = 0; i < FD; i++) cyc(0, 0, '0, 1, 0);

        // Start-of-frame discards a partial frame.
        for (int i = 0; i < 3; i++) cyc(1, 0, DW'(24'h100 + i), 0, 0);
        cyc(1, 1, 24'hAAAAAA, 0, 0);
        for (int i = 0; i < FD - 1; i++) cyc(1, 0, DW'(24'h200 + i), 0, 0);
        for (int i = 0; i < FD; i++) cyc(0, 0, '0, 1, 0);

        // Reads with nothing available are ignored; a following frame reads back intact.
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0);
        for (int i = 0; i < FD; i++) cyc(1, 0, DW'(24'h300 + i), 0, 0);
        for (int i = 0; i < FD; i++) cyc(0, 0, '0, 1, 0);

        for (int i = 0; i < 800; i++)
            cyc($urandom % 3 != 0, $urandom % 16 == 0, DW'($urandom), $urandom % 2 == 1, $urandom % 8 == 0);
        for (int i = 0; i < 2*FD + 2; i++) cyc(0, 0, '0, 1, 1);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < FD; i++) cyc(1, 0, DW'(24'h400 + i + 1), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0);
        @(negedge clk);
        wr_en_in = 1; wr_sof = 1; rd_en_in = 1; ovf_clr = 1;
        #2 chk_en = 0; reset = 0;
        #1 check_reset_outputs();
        exp_q = {}; done_q = {}; part_q = {}; rd_idx = 0; m_ovf = 0;
        @(negedge clk);
        reset = 1; chk_en = 1;
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_buf_ring.md
Name: frame_buf_ring

Overview:
- Multi-buffer successor to the single-buffer frame store. Holds NUM_BUFS complete frames of FRAME_DEPTH pixels each, in one data_mem instance.
- The write side fills frames sequentially. The read side drains whole frames in FIFO order.
- Adds back-pressure, frame alignment (start-of-frame), per-frame read markers, a frame-availability count and sticky overflow reporting.
- Sits between the pixel capture path and the display/output path.

Parameters:
- DATA_WIDTH, 24, pixel width in bits.
- ADDR_WIDTH, 3, word-address width within one frame.
- FRAME_DEPTH, 1 << ADDR_WIDTH, words per frame. Fixed by ADDR_WIDTH; do not override.
- NUM_BUFS, 2, number of frame buffers. Range 2..2^BUF_SEL_WIDTH.
- BUF_SEL_WIDTH, 1, buffer-index width. Must satisfy 2^BUF_SEL_WIDTH >= NUM_BUFS.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- reset, input, 1, asynchronous active-low reset.
- wr_en_in, input, 1, write strobe, active-low (`ASSERT). Writes data_in at the current write pointer.
- wr_sof, input, 1, active-low. Qualifies wr_en_in: this word is word 0 of a new frame.
- data_in, input, DATA_WIDTH, write pixel.
- wr_rdy, output, 1, active-high. Current write buffer can accept data.
- rd_en_in, input, 1, read strobe, active-low. Reads the next word of the oldest full frame.
- data_out, output, DATA_WIDTH, read pixel. Valid when rd_valid is high.
- rd_valid, output, 1, active-high. data_out is valid this cycle.
- rd_sof, output, 1, active-high. Concurrent with rd_valid on word 0 of a frame.
- rd_eof, output, 1, active-high. Concurrent with rd_valid on word FRAME_DEPTH-1.
- frames_avail, output, BUF_SEL_WIDTH+1, count of full, unread frames.
- overflow, output, 1, sticky. A write was attempted while wr_rdy was low.
- ovf_clr, input, 1, active-low synchronous clear of overflow.

Behaviour:
- Reset (asynchronous, reset low) clears:
  - state: wr_buf, wr_addr, rd_buf, rd_addr all 0; both FSMs to their idle states.
  - outputs: wr_rdy=1, rd_valid=0, rd_sof=0, rd_eof=0, frames_avail=0, overflow=0, data_out=0.
  - Reset mid-frame discards all buffered frames.
- Memory: single data_mem with address width ADDR_WIDTH+BUF_SEL_WIDTH; physical address = {buf_idx, word_addr}. Read latency is 1 cycle.
- Write FSM:
  - WR_FILL:
    - An accepted write (wr_en_in asserted and wr_rdy=1) stores data_in and increments wr_addr.
    - If wr_sof is asserted with the write, the data goes to word 0 and wr_addr becomes 1. Any partial frame in the current buffer is discarded.
    - A write at wr_addr=FRAME_DEPTH-1 completes the frame:
      - frames_avail increments.
      - wr_buf advances, wrapping NUM_BUFS-1 -> 0.
      - wr_addr returns to 0.
    - If the completion makes frames_avail equal NUM_BUFS, go to WR_BLOCKED.
  - WR_BLOCKED:
    - wr_rdy=0. Writes are dropped and set overflow.
    - Return to WR_FILL the cycle after any frame is released by the reader.
- Read FSM:
  - RD_IDLE: rd_en_in is ignored while frames_avail=0. Otherwise the first rd_en_in moves to RD_DRAIN and reads word 0.
  - RD_DRAIN:
    - Each asserted rd_en_in reads rd_addr and increments it. Cycles with rd_en_in deasserted are gaps: no read, no state change.
    - Reading word FRAME_DEPTH-1 releases the frame:
      - frames_avail decrements.
      - rd_buf advances with wrap.
      - rd_addr returns to 0.
      - Next state is RD_DRAIN if frames remain, else RD_IDLE.
- Read outputs: rd_valid, rd_sof and rd_eof are registered and assert exactly 1 cycle after the accepted read strobe. data_out holds its last value when rd_valid is low.
- Simultaneous frame-complete and frame-release in the same cycle: frames_avail is unchanged and wr_rdy stays 1.
- Reader and writer never touch the same buffer; read-during-write ordering is a don't-care.
- ovf_clr asserted in the same cycle as a new overflow event: set wins.
- frames_avail never exceeds NUM_BUFS and never underflows.

Decomposition:
- Shared package (frame_buf_pkg): WR_FILL/WR_BLOCKED and RD_IDLE/RD_DRAIN state encodings, plus the `ASSERT/`DEASSERT polarity constants.
- Sub-modules:
  - existing data_mem for storage.
  - frame_ptr: buffer-index/word-address counter with wrap at NUM_BUFS and a last-word flag. Instantiated once for the write side and once for the read side.

Test Plan:
- Write 8 words 0x000001..0x000008, no sof -> frames_avail=1 after the 8th write. Then 8 reads -> data_out 1..8 each 1 cycle after its strobe; rd_sof on word 1, rd_eof on word 8; frames_avail=0.
- Write 16 words with no reads -> frames_avail=2, wr_rdy=0. A 17th write is dropped and overflow=1. Pulse ovf_clr -> overflow=0. Read 1 frame -> wr_rdy=1 the cycle after release.
- With buf0 full, write the last word of buf1 in the same cycle as reading the last word of buf0 -> frames_avail stays 1 and wr_rdy stays 1.
- Write 3 words, then wr_sof with 0xAAAAAA followed by 7 more words -> exactly 1 frame completes, and reading it returns 0xAAAAAA first.
- Pulse rd_en_in with frames_avail=0 -> rd_valid stays 0 and pointers are unchanged.
- Assert reset (low) mid-drain, between clock edges -> outputs go to reset values immediately; after release frames_avail=0 and wr_rdy=1.
